// File: rtl/updi_batch_sequencer.sv
// Steps a single UPDI programmer across up to N_CHANNELS targets via a one-hot PHY select.
// Optional build macro UPDI_BATCH_RETRY_EN re-attempts failing channels up to MAX_RETRIES times.
module updi_batch_sequencer #(
    parameter int N_CHANNELS         = 4,
    parameter int SETTLE_CLKS        = 5000000,
    parameter int START_TIMEOUT_CLKS = 1000,
    parameter int MAX_RETRIES        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_CHANNELS-1:0] channel_mask,
    output logic                  busy,
    output logic                  done,
    output logic [N_CHANNELS-1:0] pass_mask,
    output logic [N_CHANNELS-1:0] fail_mask,
    output logic [N_CHANNELS-1:0] channel_en,
    output logic                  programmer_rst,
    output logic                  programmer_start,
    input  logic                  programmer_busy,
    input  logic                  phy_error
);

    localparam int CH_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int CNT_MAX = (SETTLE_CLKS > START_TIMEOUT_CLKS) ? SETTLE_CLKS : START_TIMEOUT_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CLKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_RUN       = 3'd5,
        ST_EVAL      = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [N_CHANNELS-1:0]   pending_r;
    logic [CH_W-1:0]         cur_r;
    logic [CH_W-1:0]         sel_idx_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    err_flag_r;
    logic                    can_retry_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    programmer_start_r;
    logic [N_CHANNELS-1:0]   pass_r;
    logic [N_CHANNELS-1:0]   fail_r;
    logic [N_CHANNELS-1:0]   channel_en_r;

    // Lowest-index set bit; the scan runs high to low so the last hit wins.
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CHANNELS-1:0] vec);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

    assign sel_idx_s = lowest_set(pending_r);

`ifdef UPDI_BATCH_RETRY_EN
    localparam int RTY_W = $clog2(MAX_RETRIES) + 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    logic [RTY_W-1:0] retry_cnt_r;

    assign can_retry_s = err_flag_r && (retry_cnt_r < RTY_MAX);

    // Per-channel attempt counter, restarted whenever a new channel is chosen.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_r <= '0;
        end else if (state_r == ST_SELECT) begin
            retry_cnt_r <= '0;
        end else if ((state_r == ST_EVAL) && can_retry_s) begin
            retry_cnt_r <= retry_cnt_r + RTY_W'(1);
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end
`else
    assign can_retry_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_SELECT;
                else       state_s = ST_IDLE;
            end
            ST_SELECT: begin
                if (pending_r == '0) state_s = ST_DONE;
                else                 state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) state_s = ST_START;
                else                      state_s = ST_SETTLE;
            end
            ST_START: state_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (programmer_busy)            state_s = ST_RUN;
                else if (cnt_r == TIMEOUT_LAST) state_s = ST_EVAL;
                else                            state_s = ST_WAIT_BUSY;
            end
            ST_RUN: begin
                if (!programmer_busy) state_s = ST_EVAL;
                else                  state_s = ST_RUN;
            end
            ST_EVAL: begin
                if (can_retry_s) state_s = ST_SETTLE;
                else             state_s = ST_SELECT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Batch datapath and registered outputs; strobes are decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r          <= '0;
            cur_r              <= '0;
            cnt_r              <= '0;
            err_flag_r         <= 1'b0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            programmer_start_r <= 1'b0;
            pass_r             <= '0;
            fail_r             <= '0;
            channel_en_r       <= '0;
        end else begin
            busy_r             <= (state_s != ST_IDLE);
            done_r             <= (state_s == ST_DONE);
            programmer_start_r <= (state_s == ST_START);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pending_r <= channel_mask;
                        pass_r    <= '0;
                        fail_r    <= '0;
                    end
                end
                ST_SELECT: begin
                    if (pending_r != '0) begin
                        cur_r        <= sel_idx_s;
                        channel_en_r <= N_CHANNELS'(1'b1) << sel_idx_s;
                        err_flag_r   <= 1'b0;
                        cnt_r        <= '0;
                    end
                end
                ST_SETTLE: cnt_r <= cnt_r + CNT_W'(1);
                ST_START:  cnt_r <= '0;
                ST_WAIT_BUSY: begin
                    if (!programmer_busy) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == TIMEOUT_LAST) err_flag_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (phy_error) err_flag_r <= 1'b1;
                end
                ST_EVAL: begin
                    if (can_retry_s) begin
                        err_flag_r <= 1'b0;
                        cnt_r      <= '0;
                    end else begin
                        if (err_flag_r) fail_r[cur_r] <= 1'b1;
                        else            pass_r[cur_r] <= 1'b1;
                        pending_r[cur_r] <= 1'b0;
                        channel_en_r     <= '0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign pass_mask        = pass_r;
    assign fail_mask        = fail_r;
    assign channel_en       = channel_en_r;
    assign programmer_start = programmer_start_r;
    // Held in reset during the whole settle window and while the block itself is reset.
    assign programmer_rst   = rst | (state_r == ST_SETTLE);

endmodule

// File: tb/tb_updi_batch_sequencer.sv
// Directed bench for updi_batch_sequencer with a behavioural programmer model.
module tb_updi_batch_sequencer;

    localparam int N  = 4;
    localparam int SC = 3;
    localparam int TO = 10;
    localparam int MR = 2;
`ifdef UPDI_BATCH_RETRY_EN
    localparam int EXP_ATT = MR + 1;
`else
    localparam int EXP_ATT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] channel_mask;
    logic         busy;
    logic         done;
    logic [N-1:0] pass_mask;
    logic [N-1:0] fail_mask;
    logic [N-1:0] channel_en;
    logic         programmer_rst;
    logic         programmer_start;
    logic         programmer_busy;
    logic         phy_error;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;   // 0 normal, 1 phy error every attempt, 2 never busy
    int busy_left;
    int n_start, n_rst_win, n_done, win_len, last_win_len;
    logic [N-1:0] en_q[$];
    logic [N-1:0] prev_en;
    logic         prev_prst;

    updi_batch_sequencer #(
        .N_CHANNELS(N), .SETTLE_CLKS(SC), .START_TIMEOUT_CLKS(TO), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .channel_mask(channel_mask),
        .busy(busy), .done(done), .pass_mask(pass_mask), .fail_mask(fail_mask),
        .channel_en(channel_en), .programmer_rst(programmer_rst),
        .programmer_start(programmer_start), .programmer_busy(programmer_busy),
        .phy_error(phy_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Programmer model: 20 busy cycles after each start pulse.
    initial begin
        programmer_busy = 1'b0;
        phy_error = 1'b0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            if (programmer_start && mode != 2) busy_left = 20;
            if (busy_left > 0) begin
                programmer_busy = 1'b1;
                phy_error = (mode == 1) && (busy_left == 10);
                busy_left--;
            end else begin
                programmer_busy = 1'b0;
                phy_error = 1'b0;
            end
        end
    end

    // Event monitor.
    initial begin
        n_start = 0; n_rst_win = 0; n_done = 0; win_len = 0; last_win_len = 0;
        prev_en = '0; prev_prst = 1'b0;
        forever begin
            @(negedge clk);
            if (programmer_start) n_start++;
            if (done) n_done++;
            if (programmer_rst && !prev_prst && !rst) n_rst_win++;
            if (programmer_rst && !rst) win_len++;
            else if (!programmer_rst && prev_prst) begin
                last_win_len = win_len;
                win_len = 0;
            end
            if (channel_en != prev_en && channel_en != '0) en_q.push_back(channel_en);
            prev_en = channel_en;
            prev_prst = programmer_rst;
        end
    end

    task automatic clear_stats();
        n_start = 0; n_rst_win = 0; n_done = 0; last_win_len = 0;
        en_q.delete();
    endtask

    task automatic kick(input logic [N-1:0] m);
        @(negedge clk);
        start = 1'b1;
        channel_mask = m;
        @(negedge clk);
        start = 1'b0;
        channel_mask = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check_eq("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    int lat, gap;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        channel_mask = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass_mask, 0);
        check_eq("rst_fail", fail_mask, 0);
        check_eq("rst_en", channel_en, 0);
        check_eq("rst_prst", programmer_rst, 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_prst", programmer_rst, 0);

        // Empty mask
        clear_stats();
        kick(4'b0000);
        check_eq("empty_busy", busy, 1);
        wait_done(lat);
        check_eq("empty_lat", lat, 2);
        check_eq("empty_pass", pass_mask, 0);
        check_eq("empty_fail", fail_mask, 0);
        check_eq("empty_starts", n_start, 0);
        check_eq("empty_idle", busy, 0);

        // Two clean channels
        mode = 0;
        clear_stats();
        kick(4'b1010);
        wait_done(lat);
        check_eq("two_pass", pass_mask, 4'b1010);
        check_eq("two_fail", fail_mask, 0);
        check_eq("two_starts", n_start, 2);
        check_eq("two_en_cnt", en_q.size(), 2);
        if (en_q.size() == 2) begin
            check_eq("two_en0", en_q[0], 4'b0010);
            check_eq("two_en1", en_q[1], 4'b1000);
        end
        check_eq("two_settle_len", last_win_len, SC);
        check_eq("two_done_cnt", n_done, 1);

        // PHY error on every attempt
        mode = 1;
        clear_stats();
        kick(4'b0001);
        wait_done(lat);
        check_eq("err_starts", n_start, EXP_ATT);
        check_eq("err_rstwin", n_rst_win, EXP_ATT);
        check_eq("err_fail", fail_mask, 4'b0001);
        check_eq("err_pass", pass_mask, 0);

        // Programmer never goes busy
        mode = 2;
        clear_stats();
        kick(4'b0100);
        gap = 0;
        while (!programmer_start && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check_eq("to_start_seen", programmer_start, 1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!(programmer_rst || channel_en == '0) && gap < 100);
        check_eq("to_gap", gap, TO + 2);
        wait_done(lat);
        check_eq("to_fail", fail_mask, 4'b0100);
        check_eq("to_pass", pass_mask, 0);
        check_eq("to_starts", n_start, EXP_ATT);

        // Reset mid-run on channel 1
        mode = 0;
        clear_stats();
        kick(4'b0010);
        gap = 0;
        while (!programmer_start && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        repeat (8) @(negedge clk);
        check_eq("mid_en", channel_en, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_en_clr", channel_en, 0);
        check_eq("mid_pass", pass_mask, 0);
        check_eq("mid_fail", fail_mask, 0);
        check_eq("mid_prst", programmer_rst, 1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("mid_no_done", n_done, 0);
        check_eq("mid_idle", busy, 0);

        // Second start while busy is ignored
        clear_stats();
        kick(4'b0011);
        repeat (4) @(negedge clk);
        start = 1'b1;
        channel_mask = 4'b1100;
        @(negedge clk);
        start = 1'b0;
        channel_mask = '0;
        wait_done(lat);
        check_eq("ign_pass", pass_mask, 4'b0011);
        check_eq("ign_fail", fail_mask, 0);
        check_eq("ign_starts", n_start, 2);
        repeat (10) @(negedge clk);
        check_eq("ign_idle", busy, 0);
        check_eq("ign_done_cnt", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
